// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle event pulses into clean fixed-width levels for
//   LEDs, buzzers and indicator drives. Each accepted pulse produces one
//   high level of HOLD_CYCLES followed by at least GAP_CYCLES of low.
//   Pulses that arrive while a pulse or gap is in progress are counted in
//   a saturating pending counter and replayed later. Once that counter is
//   full, further pulses are dropped and the sticky ovf flag is set.
//
//   Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN
//     When it is defined, a pulse that arrives during HOLD restarts the
//     hold timer instead of being queued. This lengthens the current level
//     and gives "activity LED" behaviour. GAP and IDLE behave the same
//     with or without the macro.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   pulse_in   single-cycle event pulse; each high cycle counts as one event
//   clr_ovf    synchronous clear of ovf; a drop in the same cycle wins
//   pulse_out  stretched output level, registered (high exactly in HOLD)
//   busy       combinational: FSM not idle or pulses still queued
//   pending    number of queued pulses not yet output
//   ovf        sticky: a pulse was dropped because the queue was full

module pulse_stretcher #(
  parameter int HOLD_CYCLES = 2_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int CNT_W       = 23,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] timer;

  // Queue bookkeeping. These terms are decoded from the current state, so
  // the FSM and the pending counter update together in the same edge.
  logic gap_end;     // last cycle of the gap, where the next pulse is picked
  logic deq;         // the gap ends and a queued pulse is launched
  logic direct;      // the gap ends with an empty queue and takes pulse_in directly
  logic enq_req;     // pulse_in must go to the queue this cycle
  logic drop;        // the queue is full and the pulse cannot be kept

  assign gap_end = (state == GAP) && (timer == GAP_LAST);
  assign deq     = gap_end && (pending != '0);
  assign direct  = gap_end && (pending == '0) && pulse_in;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  // A pulse during HOLD only extends the level and is never queued.
  assign enq_req = pulse_in && (state == GAP) && !direct;
`else
  assign enq_req = pulse_in && ((state == HOLD) || (state == GAP)) && !direct;
`endif

  // When a dequeue happens in the same cycle, it frees a slot, so a
  // saturated queue can still accept the pulse. The net count then
  // stays the same.
  assign drop = enq_req && (pending == PEND_MAX) && !deq;

  assign busy = (state != IDLE) || (pending != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      pending   <= '0;
      ovf       <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pulse_in) begin
            state     <= HOLD;
            timer     <= '0;
            pulse_out <= 1'b1;
          end
        end

        HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
          if (pulse_in) begin
            timer <= '0;
          end else
`endif
          if (timer == HOLD_LAST) begin
            state     <= GAP;
            timer     <= '0;
            pulse_out <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        GAP: begin
          if (gap_end) begin
            timer <= '0;
            if (deq || direct) begin
              state     <= HOLD;
              pulse_out <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          timer     <= '0;
          pulse_out <= 1'b0;
        end
      endcase

      // Pending counter. Enqueue and dequeue in the same cycle cancel out.
      if (enq_req && !drop && !deq)
        pending <= pending + 1'b1;
      else if (deq && !enq_req)
        pending <= pending - 1'b1;

      // If a drop and a clear happen in the same cycle, the set wins so
      // that the loss is not hidden.
      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher with HOLD=4, GAP=2 and PEND_W=2.
// The stimulus process pushes hand-computed expected output tuples into a
// queue. Each tuple is stamped with its cycle. The monitor compares the
// DUT outputs against the queue at every falling edge. Cycle numbers are
// relative to the first cycle after the reset that opens each test.
`timescale 1ns/1ps
module tb_pulse_stretcher;

  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse_in = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          pulse_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          ovf;

  pulse_stretcher #(
    .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(3), .PEND_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .clr_ovf(clr_ovf),
    .pulse_out(pulse_out), .busy(busy), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: output tuple check, 1: rising-edge count check, 2: set mark
  typedef struct {
    int            kind;
    int            cyc;
    int            tid;
    logic          po;
    logic          bz;
    logic [PW-1:0] pd;
    logic          ov;
    int            nrise;
  } exp_t;

  exp_t q[$];
  int   base = 0;
  int   tnum = 0;
  bit   done = 1'b0;

  task automatic exp(input int t, input logic po, input logic bz,
                     input logic [PW-1:0] pd, input logic ov);
    exp_t e;
    e.kind = 0; e.cyc = base + t; e.tid = tnum;
    e.po = po; e.bz = bz; e.pd = pd; e.ov = ov; e.nrise = 0;
    q.push_back(e);
  endtask

  task automatic rise_mark(input int t, input int kind, input int n);
    exp_t e;
    e.kind = kind; e.cyc = base + t; e.tid = tnum;
    e.po = 0; e.bz = 0; e.pd = '0; e.ov = 0; e.nrise = n;
    q.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   n_pass = 0;
  int   n_total = 0;
  int   rises = 0;
  int   mark = 0;
  logic po_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (pulse_out === 1'b1 && po_prev !== 1'b1) rises++;
    po_prev = pulse_out;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.kind == 2) begin
        mark = rises;
      end else if (e.cyc < cyc) begin
        n_total++;
        $display("FAIL t%0d missed_check cyc %0d: sampled at %0d, required %0d",
                 e.tid, e.cyc - base, cyc, e.cyc);
      end else if (e.kind == 1) begin
        n_total++;
        if (rises - mark == e.nrise) n_pass++;
        else $display("FAIL t%0d pulse_count: got %0d, required %0d",
                      e.tid, rises - mark, e.nrise);
      end else begin
        n_total++;
        if ({pulse_out, busy, pending, ovf} === {e.po, e.bz, e.pd, e.ov}) n_pass++;
        else $display("FAIL t%0d outputs cyc %0d {pulse_out,busy,pending,ovf}: got %b_%b_%b_%b, required %b_%b_%b_%b",
                      e.tid, cyc - base, pulse_out, busy, pending, ovf,
                      e.po, e.bz, e.pd, e.ov);
      end
    end
    if (done) begin
      n_total++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL leftover_expectations: got %0d, required 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_rel(input int t);
    while (cyc - base < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pulse_in = 1'b0; clr_ovf = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = cyc;
    rst = 1'b0;
    tnum++;
  endtask

  // Drive one mask bit per relative cycle for pulse_in, clr_ovf and rst.
  task automatic run(input int n, input logic [63:0] pm,
                     input logic [63:0] cm, input logic [63:0] rm);
    for (int t = 0; t < n; t++) begin
      wait_rel(t);
      pulse_in = pm[t]; clr_ovf = cm[t]; rst = rm[t];
    end
    wait_rel(n);
    pulse_in = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
  endtask

  function automatic logic [63:0] bits(input int a, input int b);
    logic [63:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: single pulse
    do_reset();
    exp(0, 0,0,0,0); exp(10,0,0,0,0); exp(11,1,1,0,0); exp(14,1,1,0,0);
    exp(15,0,1,0,0); exp(16,0,1,0,0); exp(17,0,0,0,0);
    run(20, bits(10,10), '0, '0);

    // T2: three back-to-back pulses are queued and replayed
    do_reset();
    exp(12,1,1,1,0); exp(13,1,1,2,0); exp(16,0,1,2,0); exp(17,1,1,1,0);
    exp(22,0,1,1,0); exp(23,1,1,0,0); exp(26,1,1,0,0); exp(27,0,1,0,0);
    exp(29,0,0,0,0);
    run(32, bits(10,12), '0, '0);

    // T3: saturation, drop, ovf, clr_ovf
    do_reset();
    rise_mark(9, 2, 0);
    exp(14,1,1,3,0); exp(15,0,1,3,1); exp(17,1,1,2,1); exp(29,1,1,0,1);
    exp(35,0,0,0,1);
    rise_mark(39, 1, 4);
    exp(40,0,0,0,1); exp(41,0,0,0,0);
    run(45, bits(10,14), bits(40,40), '0);

    // T4: pulse in the last gap cycle is taken directly
    do_reset();
    exp(16,0,1,0,0); exp(17,1,1,0,0); exp(18,1,1,0,0); exp(20,1,1,0,0);
    exp(21,0,1,0,0); exp(23,0,0,0,0);
    run(26, bits(10,10) | bits(16,16), '0, '0);

    // T5: reset in the middle of operation
    do_reset();
    exp(12,1,1,1,0); exp(13,0,0,0,0); exp(20,0,0,0,0); exp(21,1,1,0,0);
    exp(24,1,1,0,0); exp(25,0,1,0,0);
    run(28, bits(10,11) | bits(20,20), '0, bits(12,12));

    // T6: pulse during HOLD, retrigger or queue depending on build
    do_reset();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    exp(13,1,1,0,0); exp(16,1,1,0,0); exp(17,0,1,0,0); exp(18,0,1,0,0);
    exp(19,0,0,0,0);
`else
    exp(13,1,1,1,0); exp(15,0,1,1,0); exp(17,1,1,0,0); exp(20,1,1,0,0);
    exp(21,0,1,0,0); exp(23,0,0,0,0);
`endif
    run(26, bits(10,10) | bits(12,12), '0, '0);

    // T7: drop and clr_ovf in the same cycle, set wins; later clear works
    do_reset();
    exp(14,1,1,3,0); exp(15,0,1,3,1); exp(16,0,1,3,1); exp(17,1,1,2,0);
    exp(35,0,0,0,0);
    run(38, bits(10,14), bits(14,14) | bits(16,16), '0);

    repeat (2) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
